// File: rtl/butterfly_out_serializer_pkg.sv
// ---------------------------------------------------------------------------
// fft_pkg
//   Types and constants shared by the stage-1 delay line, the butterfly and
//   the butterfly output serializer.
//   - FFT_WIDTH / FFT_DATA_WIDTH / FFT_DATA_HEIGHT : default sample width,
//     lanes per vector and vectors per half-frame
//   - sample_t    : one signed butterfly output sample
//   - ser_state_t : serializer FSM states
//   - cnt_width() : width of the half-frame beat counter
// ---------------------------------------------------------------------------
package fft_pkg;

  localparam int FFT_WIDTH       = 10;
  localparam int FFT_DATA_WIDTH  = 16;
  localparam int FFT_DATA_HEIGHT = 16;

  typedef logic signed [FFT_WIDTH-1:0] sample_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PASS  = 2'd1,
    DRAIN = 2'd2
  } ser_state_t;

  // Counter width for a half-frame of 'depth' vectors; never below one bit.
  function automatic int cnt_width(input int depth);
    if (depth > 1) begin
      return $clog2(depth);
    end else begin
      return 1;
    end
  endfunction

endpackage

// File: rtl/butterfly_out_serializer_vec_buffer.sv
// ---------------------------------------------------------------------------
// vec_buffer
//   DATA_HEIGHT-deep register file of DATA_WIDTH x WIDTH bit vectors that
//   holds the butterfly difference vectors until the drain phase.
//   Ports:
//     clk      in  clock, writes on rising edge
//     rstn     in  asynchronous active-low clear of every entry
//     wr_en    in  write strobe
//     wr_addr  in  write entry index
//     wr_data  in  vector to store
//     rd_addr  in  read entry index
//     rd_data  out combinational read of entry rd_addr
// ---------------------------------------------------------------------------
module vec_buffer
  import fft_pkg::*;
#(
  parameter int WIDTH       = FFT_WIDTH,
  parameter int DATA_WIDTH  = FFT_DATA_WIDTH,
  parameter int DATA_HEIGHT = FFT_DATA_HEIGHT
) (
  input  logic                                clk,
  input  logic                                rstn,
  input  logic                                wr_en,
  input  logic [cnt_width(DATA_HEIGHT)-1:0]   wr_addr,
  input  logic [WIDTH*DATA_WIDTH-1:0]         wr_data,
  input  logic [cnt_width(DATA_HEIGHT)-1:0]   rd_addr,
  output logic [WIDTH*DATA_WIDTH-1:0]         rd_data
);

  localparam int VW = WIDTH * DATA_WIDTH;

  logic [VW-1:0] mem_r [DATA_HEIGHT];

  // Storage array: cleared on reset, one entry written per strobe.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < DATA_HEIGHT; i++) begin
        mem_r[i] <= {VW{1'b0}};
      end
    end else if (wr_en && (int'(wr_addr) < DATA_HEIGHT)) begin
      mem_r[wr_addr] <= wr_data;
    end
  end

  // Read port; an address past the last entry (non power-of-two depth) reads zero.
  always_comb begin
    rd_data = {VW{1'b0}};
    if (int'(rd_addr) < DATA_HEIGHT) begin
      rd_data = mem_r[rd_addr];
    end else begin
      rd_data = {VW{1'b0}};
    end
  end

endmodule

// File: rtl/butterfly_out_serializer.sv
// ---------------------------------------------------------------------------
// butterfly_out_serializer
//   Turns paired stage-1 butterfly results back into one vector stream.
//   Sum vectors are forwarded one cycle after they arrive; difference vectors
//   are stored and replayed, in arrival order, during the DATA_HEIGHT cycles
//   after the last input beat of the half-frame.
//   Ports:
//     clk          in  clock
//     rstn         in  asynchronous active-low reset
//     din_valid    in  a result pair is present on din_sum / din_sub
//     din_sum      in  butterfly sum vector   (lane i = bits [i*WIDTH +: WIDTH])
//     din_sub      in  butterfly difference vector
//     dout_valid   out dout carries a valid vector
//     dout         out output vector (holds when dout_valid is low)
//     dout_last    out one-cycle pulse with the final difference vector
//     err_overlap  out sticky: an input arrived while the drain was running
// ---------------------------------------------------------------------------
module butterfly_out_serializer
  import fft_pkg::*;
#(
  parameter int WIDTH       = FFT_WIDTH,
  parameter int DATA_WIDTH  = FFT_DATA_WIDTH,
  parameter int DATA_HEIGHT = FFT_DATA_HEIGHT
) (
  input  logic                        clk,
  input  logic                        rstn,
  input  logic                        din_valid,
  input  logic [WIDTH*DATA_WIDTH-1:0] din_sum,
  input  logic [WIDTH*DATA_WIDTH-1:0] din_sub,
  output logic                        dout_valid,
  output logic [WIDTH*DATA_WIDTH-1:0] dout,
  output logic                        dout_last,
  output logic                        err_overlap
);

  localparam int            VW       = WIDTH * DATA_WIDTH;
  localparam int            CW       = cnt_width(DATA_HEIGHT);
  localparam logic [CW-1:0] CNT_LAST = CW'(DATA_HEIGHT - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  ser_state_t    state_r, state_nxt_s;
  logic [CW-1:0] cnt_r, cnt_nxt_s;
  logic [VW-1:0] dout_r, dout_nxt_s;
  logic          dout_valid_r, dout_valid_nxt_s;
  logic          dout_last_r, dout_last_nxt_s;
  logic          err_r, err_nxt_s;
  logic          wr_en_s;
  logic [CW-1:0] wr_addr_s;
  logic [VW-1:0] rd_data_s;

  vec_buffer #(
    .WIDTH       (WIDTH),
    .DATA_WIDTH  (DATA_WIDTH),
    .DATA_HEIGHT (DATA_HEIGHT)
  ) u_buf (
    .clk     (clk),
    .rstn    (rstn),
    .wr_en   (wr_en_s),
    .wr_addr (wr_addr_s),
    .wr_data (din_sub),
    .rd_addr (cnt_r),
    .rd_data (rd_data_s)
  );

  // Next-state, counter, buffer write and next output values.
  always_comb begin
    state_nxt_s      = state_r;
    cnt_nxt_s        = cnt_r;
    dout_nxt_s       = dout_r;
    dout_valid_nxt_s = 1'b0;
    dout_last_nxt_s  = 1'b0;
    err_nxt_s        = err_r;
    wr_en_s          = 1'b0;
    wr_addr_s        = cnt_r;

    case (state_r)
      IDLE: begin
        if (din_valid) begin
          dout_nxt_s       = din_sum;
          dout_valid_nxt_s = 1'b1;
          wr_en_s          = 1'b1;
          wr_addr_s        = {CW{1'b0}};
          // A one-vector half-frame is complete after its first beat.
          if (DATA_HEIGHT == 1) begin
            cnt_nxt_s   = {CW{1'b0}};
            state_nxt_s = DRAIN;
          end else begin
            cnt_nxt_s   = CNT_ONE;
            state_nxt_s = PASS;
          end
        end else begin
          cnt_nxt_s = cnt_r;
        end
      end

      PASS: begin
        if (din_valid) begin
          dout_nxt_s       = din_sum;
          dout_valid_nxt_s = 1'b1;
          wr_en_s          = 1'b1;
          if (cnt_r == CNT_LAST) begin
            cnt_nxt_s   = {CW{1'b0}};
            state_nxt_s = DRAIN;
          end else begin
            cnt_nxt_s = cnt_r + CNT_ONE;
          end
        end else begin
          // Input gap: wait for the remaining beats with the count frozen.
          cnt_nxt_s = cnt_r;
        end
      end

      DRAIN: begin
        dout_nxt_s       = rd_data_s;
        dout_valid_nxt_s = 1'b1;
        if (cnt_r == CNT_LAST) begin
          dout_last_nxt_s = 1'b1;
          cnt_nxt_s       = {CW{1'b0}};
          state_nxt_s     = IDLE;
        end else begin
          cnt_nxt_s = cnt_r + CNT_ONE;
        end
        // Inputs during the drain are dropped and flagged; the drain goes on.
        if (din_valid) begin
          err_nxt_s = 1'b1;
        end else begin
          err_nxt_s = err_r;
        end
      end

      default: begin
        state_nxt_s = IDLE;
        cnt_nxt_s   = {CW{1'b0}};
      end
    endcase
  end

  // State, counter and registered outputs.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_r      <= IDLE;
      cnt_r        <= {CW{1'b0}};
      dout_r       <= {VW{1'b0}};
      dout_valid_r <= 1'b0;
      dout_last_r  <= 1'b0;
      err_r        <= 1'b0;
    end else begin
      state_r      <= state_nxt_s;
      cnt_r        <= cnt_nxt_s;
      dout_r       <= dout_nxt_s;
      dout_valid_r <= dout_valid_nxt_s;
      dout_last_r  <= dout_last_nxt_s;
      err_r        <= err_nxt_s;
    end
  end

  assign dout        = dout_r;
  assign dout_valid  = dout_valid_r;
  assign dout_last   = dout_last_r;
  assign err_overlap = err_r;

endmodule
